// File: rtl/if_stage_pipe.sv
// if_stage_pipe: instruction-fetch stage with its program counter and the IF/ID
// pipeline register (PR1). The PC and IF/ID register each have their own
// write enable, so the hazard unit can stall them separately. A downstream
// redirect overrides both stalls: it loads a new PC and flushes IF/ID to a bubble.
// Optional feature macro: STALL_COUNT_EN adds a saturating 16-bit stall counter
// and the stall_count output port.
module if_stage_pipe #(
    parameter int PC_WIDTH    = 12,
    parameter int INSTR_WIDTH = 19
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   PC_write_en,
    input  logic                   PR1_IF_ID_write_en,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_target,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] PR1_instr,
    output logic [PC_WIDTH-1:0]    PR1_pc_plus1,
    output logic                   PR1_valid,
    output logic [4:0]             PR1_opcode,
    output logic [2:0]             PR1_rd,
    output logic [2:0]             PR1_rs,
    output logic [2:0]             PR1_rt
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0]            stall_count
`endif
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [PC_WIDTH-1:0]    pc_reg;
    logic [PC_WIDTH-1:0]    pc_next;
    logic [PC_WIDTH-1:0]    pc_plus1;
    logic [INSTR_WIDTH-1:0] instr_reg;
    logic [INSTR_WIDTH-1:0] instr_next;
    logic [PC_WIDTH-1:0]    pc_plus1_reg;
    logic [PC_WIDTH-1:0]    pc_plus1_next;
    logic                   valid_reg;
    logic                   valid_next;

    // Incrementer wraps naturally modulo 2^PC_WIDTH.
    assign pc_plus1  = pc_reg + PC_ONE;
    assign imem_addr = pc_reg;

    // Next-PC selection: redirect beats a stall, a stall holds the PC.
    always_comb begin
        pc_next = pc_reg;
        if (redirect) begin
            pc_next = redirect_target;
        end else if (PC_write_en) begin
            pc_next = pc_plus1;
        end
    end

    // IF/ID next value: redirect flushes to a bubble, otherwise load or hold.
    always_comb begin
        instr_next    = instr_reg;
        pc_plus1_next = pc_plus1_reg;
        valid_next    = valid_reg;
        if (redirect) begin
            instr_next    = '0;
            pc_plus1_next = '0;
            valid_next    = 1'b0;
        end else if (PR1_IF_ID_write_en) begin
            instr_next    = imem_data;
            pc_plus1_next = pc_plus1;
            valid_next    = 1'b1;
        end
    end

    // PC and IF/ID state registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg       <= '0;
            instr_reg    <= '0;
            pc_plus1_reg <= '0;
            valid_reg    <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            pc_plus1_reg <= pc_plus1_next;
            valid_reg    <= valid_next;
        end
    end

    assign PR1_instr    = instr_reg;
    assign PR1_pc_plus1 = pc_plus1_reg;
    assign PR1_valid    = valid_reg;

    // Field decode straight off the IF/ID register; no extra pipeline delay.
    assign PR1_opcode = instr_reg[18:14];
    assign PR1_rd     = instr_reg[13:11];
    assign PR1_rs     = instr_reg[10:8];
    assign PR1_rt     = instr_reg[7:5];

`ifdef STALL_COUNT_EN
    logic [15:0] stall_count_reg;
    logic [15:0] stall_count_next;

    // A stall cycle is one where the PC is held and no redirect is pending.
    always_comb begin
        stall_count_next = stall_count_reg;
        if (!PC_write_en && !redirect && (stall_count_reg != 16'hFFFF)) begin
            stall_count_next = stall_count_reg + 16'd1;
        end
    end

    // Stall counter register; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_reg <= '0;
        end else begin
            stall_count_reg <= stall_count_next;
        end
    end

    assign stall_count = stall_count_reg;
`endif

endmodule
